// File: rtl/nos_dac_serializer_mc_if.sv
// Sample/serial bus between the sample path and the NOS DAC serializer.
interface nos_dac_serializer_mc_if #(
  parameter int CHANNELS = 2,
  parameter int MAX_BITS = 24,
  parameter int BITNUM_W = 5
);
  logic [CHANNELS*MAX_BITS-1:0] data;
  logic                         valid;
  logic                         ready;
  logic [BITNUM_W-1:0]          data_bits;
  logic                         bck_cont;
  logic                         bck;
  logic [CHANNELS-1:0]          sdata;
  logic                         le;
  logic                         busy;
  logic                         underrun;

  modport master (
    output data, valid, data_bits, bck_cont,
    input  ready, bck, sdata, le, busy, underrun
  );

  modport slave (
    input  data, valid, data_bits, bck_cont,
    output ready, bck, sdata, le, busy, underrun
  );
endinterface

// File: rtl/nos_dac_serializer_mc.sv
// Multi-channel NOS DAC serializer: one-deep hold register feeding per-channel
// MSB-first shifters with a shared bit clock and a per-frame latch enable.
module nos_dac_lane #(
  parameter int MAX_BITS = 24,
  parameter int BITNUM_W = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic                shift,
  input  logic [MAX_BITS-1:0] word,
  input  logic [BITNUM_W-1:0] sh_amt,
  output logic                msb
);
  logic [MAX_BITS-1:0] sh;

  // Left-align the n-bit word so its bit n-1 sits at the MSB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    sh <= '0;
    else if (load)  sh <= word << sh_amt;
    else if (shift) sh <= sh << 1;
  end

  assign msb = sh[MAX_BITS-1];
endmodule

module nos_dac_serializer_mc #(
  parameter int CHANNELS = 2,
  parameter int MAX_BITS = 24,
  parameter int BITNUM_W = 5
) (
  input logic                    clk,
  input logic                    resetn,
  nos_dac_serializer_mc_if.slave bus
);
  localparam logic [BITNUM_W-1:0] MAXB = BITNUM_W'(MAX_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t                       state, state_nxt;
  logic [CHANNELS*MAX_BITS-1:0] hold_q;
  logic                         hold_full;
  logic                         phase;
  logic [BITNUM_W-1:0]          bcnt;
  logic                         cont_q;
  logic                         bck_prev;
  logic [BITNUM_W-1:0]          n_sel, sh_amt;
  logic                         load, accept, shift_en, latch_end;
  logic                         bck_c, le_c, ur_c, sd_en;
  logic [CHANNELS-1:0]          msb;

  always_comb begin
    n_sel = bus.data_bits;
    if (bus.data_bits == '0 || bus.data_bits > MAXB) n_sel = MAXB;
  end
  assign sh_amt = MAXB - n_sel;

  assign latch_end = (state == LATCH) && phase;
  assign load      = hold_full && ((state == IDLE) || latch_end);
  assign bus.ready = !hold_full || load;
  assign accept    = bus.valid && bus.ready;
  assign shift_en  = (state == SHIFT) && phase;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (phase && bcnt == '0) state_nxt = LATCH;
      LATCH:   if (phase) state_nxt = hold_full ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Idle bck in continuous mode is derived from last cycle's bck so the
  // toggle never skips when leaving LATCH.
  always_comb begin
    bck_c = 1'b0;
    le_c  = 1'b0;
    ur_c  = 1'b0;
    sd_en = 1'b0;
    case (state)
      IDLE:  bck_c = bus.bck_cont && !bck_prev;
      SHIFT: begin bck_c = phase; sd_en = 1'b1; end
      LATCH: begin
        bck_c = cont_q && phase;
        le_c  = 1'b1;
        ur_c  = phase && !hold_full && cont_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
      phase     <= 1'b0;
      bcnt      <= '0;
      cont_q    <= 1'b0;
      bck_prev  <= 1'b0;
    end else begin
      bck_prev <= bck_c;
      if (accept) hold_q <= bus.data;
      if (accept)    hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;
      if (load) begin
        phase  <= 1'b0;
        bcnt   <= n_sel - 1'b1;
        cont_q <= bus.bck_cont;
      end else begin
        if (state != IDLE) phase <= !phase;
        if (shift_en && bcnt != '0) bcnt <= bcnt - 1'b1;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    nos_dac_lane #(.MAX_BITS(MAX_BITS), .BITNUM_W(BITNUM_W)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .load   (load),
      .shift  (shift_en),
      .word   (hold_q[k*MAX_BITS +: MAX_BITS]),
      .sh_amt (sh_amt),
      .msb    (msb[k])
    );
  end

  assign bus.bck      = bck_c;
  assign bus.le       = le_c;
  assign bus.underrun = ur_c;
  assign bus.sdata    = msb & {CHANNELS{sd_en}};
  assign bus.busy     = (state != IDLE) || hold_full;
endmodule

// File: tb/tb_nos_dac_serializer_mc.sv
// Directed bench for nos_dac_serializer_mc with a frame scoreboard checked at each le.
module tb_nos_dac_serializer_mc;
  localparam int CH = 2;
  localparam int MB = 24;
  localparam int BW = 5;

  typedef struct {
    logic [CH*MB-1:0] d;
    int               n;
    bit               cont;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;

  nos_dac_serializer_mc_if #(.CHANNELS(CH), .MAX_BITS(MB), .BITNUM_W(BW)) bus ();

  nos_dac_serializer_mc #(.CHANNELS(CH), .MAX_BITS(MB), .BITNUM_W(BW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          le_rise_q[$];
  logic [31:0] cap [CH];
  int          rises = 0, lecnt = 0, frames = 0, ur_cnt = 0, ur_le = 0, rdy_low = 0, cyc = 0;
  logic        bck_s = 1'b0, le_s = 1'b0;
  bit          tog_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampn(input int db);
    return (db == 0 || db > MB) ? MB : db;
  endfunction

  // Monitor: collect sdata on bck rises inside a frame, score the frame at le.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] m;
    cyc++;
    if (!resetn) begin
      rises = 0;
      lecnt = 0;
      for (int k = 0; k < CH; k++) cap[k] = '0;
    end else begin
      if (bus.bck && !bck_s && !bus.le && bus.busy) begin
        rises++;
        for (int k = 0; k < CH; k++) cap[k] = {cap[k][30:0], bus.sdata[k]};
      end
      if (bus.le && !le_s) begin
        le_rise_q.push_back(cyc);
        frames++;
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          m = (32'h1 << e.n) - 32'h1;
          for (int k = 0; k < CH; k++)
            chk("ch_data", {32'h0, cap[k] & m}, {32'h0, 32'(e.d[k*MB +: MB]) & m});
          if (!e.cont) chk("bck_rises", rises, e.n);
        end
        rises = 0;
      end
      if (bus.le) lecnt++;
      if (!bus.le && le_s) begin
        chk("le_width", lecnt, 2);
        lecnt = 0;
      end
      if (tog_chk) chk("bck_toggle", bus.bck, !bck_s);
      if (bus.underrun) begin
        ur_cnt++;
        if (bus.le) ur_le++;
      end
      if (!bus.ready) rdy_low++;
    end
    bck_s = bus.bck;
    le_s  = bus.le;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [23:0] w0, input logic [23:0] w1, input int db,
                      input bit cont, output bit acc_le);
    exp_t e;
    bit   done = 1'b0;
    bus.data      = {w1, w0};
    bus.data_bits = BW'(db);
    bus.bck_cont  = cont;
    bus.valid     = 1'b1;
    acc_le        = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        e.d    = {w1, w0};
        e.n    = clampn(db);
        e.cont = cont;
        sb.push_back(e);
        acc_le = bus.le;
        done   = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.le) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
    tick(2);
  endtask

  task automatic wait_rises(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rises >= n) ok = 1'b1;
    end
    if (!ok) chk("rise_timeout", 0, 1);
  endtask

  initial begin
    bit acc_le [4];
    bit dummy;
    int base, rl0, fr0;

    bus.data = '0; bus.valid = 1'b0; bus.data_bits = BW'(16); bus.bck_cont = 1'b0;

    // Reset state
    #12;
    chk("rst_bck", bus.bck, 0);
    chk("rst_sdata", bus.sdata, 0);
    chk("rst_le", bus.le, 0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_underrun", bus.underrun, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(3);

    // Single 16-bit word, gated bck
    send(24'h34ABCD, 24'h008001, 16, 1'b0, dummy);
    drain();
    chk("t1_frames", frames, 1);
    chk("t1_idle_bck", bus.bck, 0);
    chk("t1_idle_ready", bus.ready, 1);
    chk("t1_idle_underrun", bus.underrun, 0);
    chk("t1_idle_sdata", bus.sdata, 0);

    // Back-to-back 24-bit stream
    base = le_rise_q.size();
    rl0  = rdy_low;
    send(24'hA5A5A5, 24'h123456, 24, 1'b0, acc_le[0]);
    send(24'h5A5A5A, 24'h654321, 24, 1'b0, acc_le[1]);
    send(24'hFFFFFF, 24'h800001, 24, 1'b0, acc_le[2]);
    send(24'h0F0F0F, 24'hC3C3C3, 24, 1'b0, acc_le[3]);
    drain();
    chk("t2_frames", le_rise_q.size() - base, 4);
    for (int i = 1; i < 4; i++)
      if (le_rise_q.size() > base + i)
        chk("t2_period", le_rise_q[base+i] - le_rise_q[base+i-1], 50);
    chk("t2_ready_low", rdy_low > rl0, 1);
    chk("t2_acc_at_load3", acc_le[2], 1);
    chk("t2_acc_at_load4", acc_le[3], 1);

    // Clamp and mid-frame data_bits change
    send(24'h9ABCDE, 24'h13579B, 0, 1'b0, dummy);
    drain();
    send(24'hFEDCBA, 24'h2468AC, 31, 1'b0, dummy);
    wait_rises(3);
    bus.data_bits = BW'(8);
    drain();
    send(24'h7654C3, 24'h11113C, 8, 1'b0, dummy);
    drain();
    chk("t3_queue_empty", sb.size(), 0);
    chk("t3_no_underrun_gated", ur_cnt, 0);

    // Continuous bck
    bus.bck_cont = 1'b1;
    tog_chk = 1'b1;
    tick(1);
    send(24'hC0FFEE, 24'hBEEF01, 20, 1'b1, dummy);
    drain();
    tick(6);
    tog_chk = 1'b0;
    bus.bck_cont = 1'b0;
    tick(2);
    chk("t4_underrun_cnt", ur_cnt, 1);
    chk("t4_underrun_in_latch", ur_le, 1);
    chk("t4_gated_idle_bck", bus.bck, 0);

    // Reset mid-SHIFT
    send(24'h00F0F0, 24'h00AAAA, 16, 1'b0, dummy);
    wait_rises(7);
    fr0 = frames;
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_bck", bus.bck, 0);
    chk("t5_sdata", bus.sdata, 0);
    chk("t5_le", bus.le, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_ready", bus.ready, 1);
    sb.delete();
    tick(3);
    resetn = 1'b1;
    tick(40);
    chk("t5_no_le", frames, fr0);
    send(24'h00C3A5, 24'h005A3C, 16, 1'b0, dummy);
    drain();
    chk("t5_recover_frames", frames, fr0 + 1);
    chk("end_queue_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
